clk_probe_unit: RTL and testbench
=================================

# clk_probe_unit

Board-level clock and debug support block placed between the FPGA board clock and the pipelined processor core. It derives the core clock by integer division of the board clock, reports a lock indication once the derived clock is stable, and captures a 32-bit probe word from the core (typically its LED/result register) into a readable snapshot with change detection. It stands in for the vendor clocking wizard and virtual-I/O probe so that the top-level wrapper is fully synthesizable and simulatable.

## Interface
- DIV_HALF, 1: board-clock cycles per half-period of the derived clock; must be ≥1, giving a divide ratio of 2·DIV_HALF.
- LOCK_CYCLES, 16: board-clock cycles after reset release before lock is declared; must be ≥1.
- PW, 32: probe width.

Ports:
- w_clk  in  1  board clock; all logic is clocked on its rising edge.
- w_rst  in  1  reset, synchronous, active-high.
- w_clk_out  out  1  derived core clock, registered.
- w_locked  out  1  derived clock is stable.
- w_probe_in  in  PW  probe word from the core.
- w_freeze  in  1  hold the current snapshot.
- r_probe  out  PW  registered probe snapshot.
- r_change  out  1  one-cycle pulse: the snapshot just changed.
- r_chg_cnt  out  32  number of snapshot changes since reset.
- r_led  out  4  per-byte parity of the snapshot; see Configuration.

## Operation
- Divider: counter div_cnt in 0..DIV_HALF-1; when div_cnt==DIV_HALF-1, toggle w_clk_out and clear div_cnt, else increment.
- Lock: counter lock_cnt saturates at LOCK_CYCLES and increments every cycle while w_rst=0. w_locked=1 exactly when lock_cnt==LOCK_CYCLES.
- Capture: when w_locked=1 and w_freeze=0, r_probe<=w_probe_in; otherwise r_probe holds.
- Change: r_change=1 for one cycle when a capture loads a value different from the current r_probe; r_chg_cnt increments on the same cycle and wraps from 2^32-1 to 0.
- If w_freeze is high, no capture, no r_change and no count, even when w_probe_in changes. Updates resume on the first cycle after w_freeze falls.
- While w_locked=0, the probe path is inert: r_probe, r_change and r_chg_cnt hold.

## Timing
- Reset values, applied at the w_clk edge where w_rst=1: w_clk_out=0, div_cnt=0, lock_cnt=0, w_locked=0, r_probe=0, r_change=0, r_chg_cnt=0, r_led=0.
- A reset asserted mid-operation behaves identically and drops w_locked on the next edge.
- Derived clock: with DIV_HALF=1, w_clk_out toggles on every edge after reset. The first rise is at the DIV_HALF-th edge with w_rst=0.
- Lock latency: counting the first edge with w_rst=0 as edge 1, w_locked rises after edge LOCK_CYCLES and stays high until the next reset.
- Capture latency: 1 cycle from w_probe_in to r_probe. r_change and r_chg_cnt update on the same edge as r_probe.
- r_led is combinational from r_probe; it adds no latency beyond r_probe.

## Configuration
- PROBE_LEDS_EN defined: r_led = {^r_probe[31:24], ^r_probe[23:16], ^r_probe[15:8], ^r_probe[7:0]}, i.e. the XOR-reduction of each snapshot byte. Requires PW=32.
- PROBE_LEDS_EN undefined: the r_led port still exists, is tied to 0, and has no parity logic.

## Test plan
- Reset and lock: hold w_rst=1 for 3 cycles, then release with LOCK_CYCLES=16 → all outputs are 0; w_locked is 0 through edge 15 and 1 from edge 16 onward.
- Divider: DIV_HALF=2 → w_clk_out has a period of 4 w_clk cycles and 50% duty; the first rise is at edge 2 after release.
- Capture and change: after lock, w_probe_in=0x0000_0005 for 1 cycle, then held → r_probe=5 one cycle later, r_change pulses once, r_chg_cnt=1. A repeated 5 gives no pulse.
- Freeze: with w_freeze=1, drive w_probe_in=0xDEAD_BEEF → r_probe stays 5 and r_chg_cnt stays 1. Lowering w_freeze gives r_probe=0xDEADBEEF and r_chg_cnt=2.
- Pre-lock and mid-run reset: vary w_probe_in before lock → r_probe stays 0. Assert w_rst mid-run → all outputs are 0 on the next edge and lock restarts.
- LEDs with PROBE_LEDS_EN: r_probe=0x0100_0301 → r_led=4'b1001. Without the macro → r_led=0.

Source files
------------

// File: rtl/clk_probe_unit.sv
// ---------------------------------------------------------------------------
// clk_probe_unit
//
// Board-level clock and debug helper placed between the board clock and the
// processor core. It replaces a vendor clocking wizard and virtual-I/O probe
// with plain synthesizable logic:
//   * divides the board clock by 2*DIV_HALF to produce the core clock,
//   * raises a lock flag LOCK_CYCLES board cycles after reset release,
//   * snapshots a probe word from the core, with a one-cycle change pulse
//     and a running count of snapshot changes.
//
// Optional feature macro: PROBE_LEDS_EN
//   defined   -> r_led shows the XOR parity of each byte of the snapshot
//                (requires PW = 32)
//   undefined -> r_led exists but is tied to zero
//
// Parameters
//   DIV_HALF     board cycles per half-period of w_clk_out (>= 1)
//   LOCK_CYCLES  board cycles after reset release until w_locked (>= 1)
//   PW           probe width
//
// Ports
//   w_clk       in   board clock, all logic on its rising edge
//   w_rst       in   synchronous active-high reset
//   w_clk_out   out  derived core clock (registered)
//   w_locked    out  derived clock is stable
//   w_probe_in  in   probe word from the core
//   w_freeze    in   hold the current snapshot
//   r_probe     out  registered probe snapshot
//   r_change    out  one-cycle pulse when the snapshot changes
//   r_chg_cnt   out  snapshot changes since reset (wraps)
//   r_led       out  per-byte parity of the snapshot (or zero)
//
// Handshake: there is no valid/ready pair. The probe path samples
// w_probe_in on every edge where w_locked=1 and w_freeze=0; r_change marks
// the cycle whose snapshot differs from the previous one.
// ---------------------------------------------------------------------------
module clk_probe_unit #(
    parameter int DIV_HALF    = 1,
    parameter int LOCK_CYCLES = 16,
    parameter int PW          = 32
) (
    input  logic          w_clk,
    input  logic          w_rst,
    output logic          w_clk_out,
    output logic          w_locked,
    input  logic [PW-1:0] w_probe_in,
    input  logic          w_freeze,
    output logic [PW-1:0] r_probe,
    output logic          r_change,
    output logic [31:0]   r_chg_cnt,
    output logic [3:0]    r_led
);

    // Counter widths; a single bit is kept even when DIV_HALF=1 so the
    // divider counter is never a zero-width vector.
    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    // -----------------------------------------------------------------------
    // Clock divider
    // -----------------------------------------------------------------------
    logic [DW-1:0] r_div_cnt;
    logic          r_clk_out;
    logic          w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_div_cnt <= '0;
            r_clk_out <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_clk_out <= ~r_clk_out;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_clk_out = r_clk_out;

    // -----------------------------------------------------------------------
    // Lock indication: saturating count of non-reset edges. Lock is a plain
    // compare against the registered count, so it drops on the edge that
    // samples reset and rises right after edge LOCK_CYCLES.
    // -----------------------------------------------------------------------
    logic [LW-1:0] r_lock_cnt;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_lock_cnt <= '0;
        end else if (r_lock_cnt != LOCK_MAX) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign w_locked = (r_lock_cnt == LOCK_MAX);

    // -----------------------------------------------------------------------
    // Probe capture and change detection. The lock flag used here is the
    // value before the edge, so the first capture happens on the edge after
    // lock is reported.
    // -----------------------------------------------------------------------
    logic w_capture;
    logic w_differs;

    assign w_capture = w_locked & ~w_freeze;
    assign w_differs = (w_probe_in != r_probe);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_probe   <= '0;
            r_change  <= 1'b0;
            r_chg_cnt <= '0;
        end else if (w_capture) begin
            r_probe  <= w_probe_in;
            r_change <= w_differs;
            if (w_differs) begin
                r_chg_cnt <= r_chg_cnt + 32'd1;
            end
        end else begin
            // Frozen or unlocked: snapshot and count hold, no pulse.
            r_change <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Snapshot LEDs
    // -----------------------------------------------------------------------
`ifdef PROBE_LEDS_EN
    assign r_led = {^r_probe[31:24], ^r_probe[23:16], ^r_probe[15:8], ^r_probe[7:0]};
`else
    assign r_led = 4'b0000;
`endif

endmodule

// File: tb/tb_clk_probe_unit.sv
// ---------------------------------------------------------------------------
// tb_clk_probe_unit
//
// Bench for clk_probe_unit with DIV_HALF=2, LOCK_CYCLES=16, PW=32.
// The driver applies one set of inputs per cycle and pushes the outputs the
// reference model predicts after the following rising edge; the monitor pops
// one prediction per falling edge and compares every output field.
// The reference model works from "edges since reset release": the divided
// clock is (n / DIV_HALF) % 2, lock is n >= LOCK_CYCLES, and the snapshot
// follows the capture/freeze rules directly.
// ---------------------------------------------------------------------------
module tb_clk_probe_unit;

    localparam int DH = 2;
    localparam int LC = 16;
    localparam int W  = 71;  // {clk_out, locked, probe[32], change, cnt[32], led[4]}

    logic        clk;
    logic        rst;
    logic        clk_out;
    logic        locked;
    logic [31:0] probe_in;
    logic        freeze;
    logic [31:0] probe;
    logic        change;
    logic [31:0] chg_cnt;
    logic [3:0]  led;

    clk_probe_unit #(
        .DIV_HALF    (DH),
        .LOCK_CYCLES (LC),
        .PW          (32)
    ) dut (
        .w_clk      (clk),
        .w_rst      (rst),
        .w_clk_out  (clk_out),
        .w_locked   (locked),
        .w_probe_in (probe_in),
        .w_freeze   (freeze),
        .r_probe    (probe),
        .r_change   (change),
        .r_chg_cnt  (chg_cnt),
        .r_led      (led)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_n     = 0;
    logic [31:0] m_probe = '0;
    logic [31:0] m_cnt   = '0;
    logic        m_chg   = 1'b0;

    function automatic logic [3:0] led_of(input logic [31:0] v);
`ifdef PROBE_LEDS_EN
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b] = ^v[8*b +: 8];
        end
        return r;
`else
        return 4'b0000;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [31:0] pin, input logic frz);
        logic         m_clk;
        logic         m_lock;
        logic [W-1:0] e;
        rst      = r;
        probe_in = pin;
        freeze   = frz;
        if (r) begin
            m_n     = 0;
            m_probe = '0;
            m_cnt   = '0;
            m_chg   = 1'b0;
        end else begin
            // Capture decision uses the lock state before this edge.
            if ((m_n >= LC) && !frz) begin
                m_chg = (pin != m_probe);
                if (m_chg) m_cnt = m_cnt + 32'd1;
                m_probe = pin;
            end else begin
                m_chg = 1'b0;
            end
            if (m_n < 1000000) m_n++;
        end
        m_clk  = ((m_n / DH) % 2) == 1;
        m_lock = (m_n >= LC);
        e = {m_clk, m_lock, m_probe, m_chg, m_cnt, led_of(m_probe)};
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("clk_out", {31'd0, clk_out}, {31'd0, e[70]});
            check("locked",  {31'd0, locked},  {31'd0, e[69]});
            check("probe",   probe,            e[68:37]);
            check("change",  {31'd0, change},  {31'd0, e[36]});
            check("chg_cnt", chg_cnt,          e[35:4]);
            check("led",     {28'd0, led},     {28'd0, e[3:0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] last;
        logic [31:0] pin;
        int          sel;
        rst      = 1'b1;
        probe_in = '0;
        freeze   = 1'b0;

        // Reset for 3 cycles, then pre-lock with varying probe values.
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0);
        for (int i = 0; i < LC; i++) drive(1'b0, $urandom, 1'b0);

        // Directed capture / repeat / freeze / unfreeze / LED pattern.
        drive(1'b0, 32'h0000_0005, 1'b0);
        drive(1'b0, 32'h0000_0005, 1'b0);
        drive(1'b0, 32'h0000_0005, 1'b0);
        drive(1'b0, 32'hDEAD_BEEF, 1'b1);
        drive(1'b0, 32'hDEAD_BEEF, 1'b1);
        drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 32'h0100_0301, 1'b0);
        drive(1'b0, 32'h0100_0301, 1'b0);

        // Mid-run reset, then relock.
        drive(1'b1, 32'h1234_5678, 1'b0);
        for (int i = 0; i < LC + 4; i++) drive(1'b0, $urandom, 1'b0);

        // Randomized run with repeats, freezes and rare resets.
        last = 32'h0;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      pin = last;
            else if (sel == 1) pin = 32'($urandom_range(0, 3));
            else               pin = $urandom;
            last = pin;
            drive(($urandom_range(0, 99) == 0), pin, ($urandom_range(0, 3) == 0));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
